// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard unit for the 5-stage MIPS pipeline: stall/flush/branch
// forwarding controls plus the busy tracker of the shared mult/div unit.
module hazard_stall_controller #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_d,
    input  logic [5:0] opcode_d,
    input  logic [5:0] funct_d,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] writereg_e,
    input  logic       regwrite_e,
    input  logic       memtoreg_e,
    input  logic [4:0] writereg_m,
    input  logic       regwrite_m,
    input  logic       memtoreg_m,
    input  logic       branch_taken_d,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic       md_issue,
    output logic       md_busy
);

    localparam int unsigned REG_W = 5;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MD_LATENCY - 1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_special, is_md, is_mfx, is_br, is_jr, is_j;
    logic rs_nz, rt_nz, e_rs, e_rt, m_rs, m_rt;
    logic lw_stall, br_stall, md_stall, stall;
    logic busy_c, issue_c;

    // Instruction classes; a bubble in D belongs to none of them
    assign is_special = (opcode_d == 6'h00);
    assign is_md  = valid_d & is_special & (funct_d[5:2] == 4'b0110);
    assign is_mfx = valid_d & is_special & ((funct_d == 6'h10) | (funct_d == 6'h12));
    assign is_br  = valid_d & ((opcode_d == 6'h04) | (opcode_d == 6'h05));
    assign is_jr  = valid_d & is_special & (funct_d == 6'h08);
    assign is_j   = valid_d & ((opcode_d == 6'h02) | (opcode_d == 6'h03));

    // $0 is hardwired, so it never creates a dependency
    assign rs_nz = (rs_d != REG_W'(0));
    assign rt_nz = (rt_d != REG_W'(0));
    assign e_rs  = rs_nz & (writereg_e == rs_d);
    assign e_rt  = rt_nz & (writereg_e == rt_d);
    assign m_rs  = rs_nz & (writereg_m == rs_d);
    assign m_rt  = rt_nz & (writereg_m == rt_d);

    assign lw_stall = valid_d & memtoreg_e & regwrite_e & (e_rs | e_rt);
    assign br_stall = (is_br | is_jr) &
                      ((regwrite_e & (e_rs | (is_br & e_rt))) |
                       (memtoreg_m & (m_rs | (is_br & m_rt))));
    assign busy_c   = (state_q == MD_BUSY);
    assign md_stall = busy_c & (is_mfx | is_md);
    assign stall    = lw_stall | br_stall | md_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mult/div occupancy: a unit latency of one never leaves IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue_c = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (is_md & ~lw_stall & ~br_stall) begin
                    issue_c = 1'b1;
                    if (MD_LATENCY > 1) begin
                        state_d = MD_BUSY;
                        cnt_d   = CNT_RELOAD;
                    end
                end
            end
            MD_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_f  = ~rst & stall;
    assign stall_d  = ~rst & stall;
    assign flush_e  = ~rst & stall;
    assign flush_d  = ~rst & (branch_taken_d | is_j | is_jr) & ~stall;
    assign fwd_a_d  = ~rst & regwrite_m & ~memtoreg_m & m_rs;
    assign fwd_b_d  = ~rst & regwrite_m & ~memtoreg_m & m_rt;
    assign md_issue = ~rst & issue_c;
    assign md_busy  = ~rst & busy_c;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller; outputs are compared as one
// packed vector {stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, md_issue, md_busy}.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_d;
    logic [5:0] opcode_d, funct_d;
    logic [4:0] rs_d, rt_d, writereg_e, writereg_m;
    logic       regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, branch_taken_d;
    logic       stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, md_issue, md_busy;
    logic [7:0] outs;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] O_NONE   = 8'b0000_0000;
    localparam logic [7:0] O_STALL  = 8'b1101_0000;
    localparam logic [7:0] O_FLUSHD = 8'b0010_0000;
    localparam logic [7:0] O_FWDB   = 8'b0000_0100;
    localparam logic [7:0] O_ISSUE  = 8'b0000_0010;
    localparam logic [7:0] O_BUSY   = 8'b0000_0001;
    localparam logic [7:0] O_BSTALL = 8'b1101_0001;

    hazard_stall_controller #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .valid_d(valid_d), .opcode_d(opcode_d),
        .funct_d(funct_d), .rs_d(rs_d), .rt_d(rt_d),
        .writereg_e(writereg_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .writereg_m(writereg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
        .branch_taken_d(branch_taken_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .md_issue(md_issue), .md_busy(md_busy)
    );

    always #5 clk = ~clk;
    assign outs = {stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, md_issue, md_busy};

    task automatic clear_inputs();
        valid_d = 0; opcode_d = 0; funct_d = 0; rs_d = 0; rt_d = 0;
        writereg_e = 0; regwrite_e = 0; memtoreg_e = 0;
        writereg_m = 0; regwrite_m = 0; memtoreg_m = 0; branch_taken_d = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt);
        valid_d = 1; opcode_d = op; funct_d = fn; rs_d = rs; rt_d = rt;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        set_d(6'h00, 6'h20, 5'd8, 5'd9);
        writereg_e = 8; regwrite_e = 1; memtoreg_e = 1;
        #2;
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs, O_NONE);
        end
        step();
        rst = 0;
        clear_inputs();
        #1;
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected %b", outs, O_NONE);
        end
    endtask

    task automatic test_load_use();
        step();
        clear_inputs();
        set_d(6'h00, 6'h20, 5'd8, 5'd3);
        writereg_e = 8; regwrite_e = 1; memtoreg_e = 1;
        #1;
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL load_use_stall: got %b expected %b", outs, O_STALL);
        end
        step();
        writereg_e = 0; regwrite_e = 0; memtoreg_e = 0;
        #1;
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL load_use_release: got %b expected %b", outs, O_NONE);
        end
    endtask

    task automatic test_zero_reg();
        step();
        clear_inputs();
        set_d(6'h00, 6'h20, 5'd0, 5'd0);
        writereg_e = 0; regwrite_e = 1; memtoreg_e = 1;
        #1;
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL zero_reg_no_stall: got %b expected %b", outs, O_NONE);
        end
        valid_d = 0;
        rs_d = 4; writereg_e = 4;
        #1;
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL bubble_masks_hazard: got %b expected %b", outs, O_NONE);
        end
    endtask

    task automatic test_branch();
        step();
        clear_inputs();
        set_d(6'h04, 6'h00, 5'd2, 5'd5);
        writereg_m = 5; regwrite_m = 1; memtoreg_m = 0;
        #1;
        checks++;
        if (outs !== O_FWDB) begin
            errors++;
            $display("FAIL branch_fwd_b: got %b expected %b", outs, O_FWDB);
        end
        step();
        clear_inputs();
        set_d(6'h04, 6'h00, 5'd2, 5'd5);
        writereg_e = 5; regwrite_e = 1; branch_taken_d = 1;
        #1;
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL branch_stall_no_flush: got %b expected %b", outs, O_STALL);
        end
        step();
        regwrite_e = 0;
        #1;
        checks++;
        if (outs !== O_FLUSHD) begin
            errors++;
            $display("FAIL branch_flush_after_release: got %b expected %b", outs, O_FLUSHD);
        end
        step();
        clear_inputs();
        set_d(6'h04, 6'h00, 5'd2, 5'd7);
        writereg_m = 7; regwrite_m = 1; memtoreg_m = 1;
        #1;
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL branch_load_in_m_stall: got %b expected %b", outs, O_STALL);
        end
        // jr compares rs only, so a matching rt must not stall it
        step();
        clear_inputs();
        set_d(6'h00, 6'h08, 5'd2, 5'd6);
        writereg_e = 6; regwrite_e = 1;
        #1;
        checks++;
        if (outs !== O_FLUSHD) begin
            errors++;
            $display("FAIL jr_rt_ignored: got %b expected %b", outs, O_FLUSHD);
        end
        rs_d = 6;
        #1;
        checks++;
        if (outs !== O_STALL) begin
            errors++;
            $display("FAIL jr_rs_stall: got %b expected %b", outs, O_STALL);
        end
    endtask

    task automatic test_mult_mflo();
        step();
        clear_inputs();
        set_d(6'h00, 6'h18, 5'd2, 5'd3);
        #1;
        checks++;
        if (outs !== O_ISSUE) begin
            errors++;
            $display("FAIL mult_issue: got %b expected %b", outs, O_ISSUE);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            set_d(6'h00, 6'h12, 5'd0, 5'd0);
            #1;
            checks++;
            if (outs !== O_BSTALL) begin
                errors++;
                $display("FAIL mflo_stall_cycle%0d: got %b expected %b", i, outs, O_BSTALL);
            end
        end
        step();
        #1;
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL mflo_proceeds: got %b expected %b", outs, O_NONE);
        end
    endtask

    task automatic test_back_to_back();
        step();
        clear_inputs();
        set_d(6'h00, 6'h19, 5'd2, 5'd3);
        #1;
        checks++;
        if (outs !== O_ISSUE) begin
            errors++;
            $display("FAIL b2b_first_issue: got %b expected %b", outs, O_ISSUE);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            set_d(6'h00, 6'h1A, 5'd4, 5'd5);
            #1;
            checks++;
            if (outs !== O_BSTALL) begin
                errors++;
                $display("FAIL div_wait_cycle%0d: got %b expected %b", i, outs, O_BSTALL);
            end
        end
        step();
        #1;
        checks++;
        if (outs !== O_ISSUE) begin
            errors++;
            $display("FAIL div_issue: got %b expected %b", outs, O_ISSUE);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (outs !== O_BUSY) begin
            errors++;
            $display("FAIL div_busy: got %b expected %b", outs, O_BUSY);
        end
        repeat (4) step();
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL div_done_idle: got %b expected %b", outs, O_NONE);
        end
    endtask

    task automatic test_reset_mid_busy();
        step();
        clear_inputs();
        set_d(6'h00, 6'h18, 5'd2, 5'd3);
        #1;
        checks++;
        if (outs !== O_ISSUE) begin
            errors++;
            $display("FAIL rst_test_issue: got %b expected %b", outs, O_ISSUE);
        end
        step();
        clear_inputs();
        step();
        checks++;
        if (outs !== O_BUSY) begin
            errors++;
            $display("FAIL rst_test_busy2: got %b expected %b", outs, O_BUSY);
        end
        #1;
        rst = 1;
        set_d(6'h00, 6'h18, 5'd2, 5'd3);
        #1;
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL rst_async_clear: got %b expected %b", outs, O_NONE);
        end
        step();
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL rst_held_outputs: got %b expected %b", outs, O_NONE);
        end
        rst = 0;
        #1;
        checks++;
        if (outs !== O_ISSUE) begin
            errors++;
            $display("FAIL rst_new_mult_issue: got %b expected %b", outs, O_ISSUE);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (outs !== O_BUSY) begin
            errors++;
            $display("FAIL rst_new_mult_busy: got %b expected %b", outs, O_BUSY);
        end
        repeat (4) step();
        checks++;
        if (outs !== O_NONE) begin
            errors++;
            $display("FAIL rst_new_mult_done: got %b expected %b", outs, O_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_mult_mflo();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
